cache_fill_fsm: RTL and testbench



---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_fill_fsm_if.sv | 30 +++
 rtl/cache_fill_fsm_fill_counter.sv | 33 +++
 rtl/cache_fill_fsm.sv | 114 +++++++++++
 tb/tb_cache_fill_fsm.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
// Block geometry is fixed at 8 x 16-bit words, a 16-byte block.
package cache_pkg;

    typedef enum logic {
        FILL_IDLE   = 1'b0,
        FILL_ACTIVE = 1'b1
    } fill_state_e;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;
    localparam int CNT_BITS          = WORD_IDX_BITS + 1;
    localparam int MEM_LATENCY       = 4;

    localparam logic [15:0] BLOCK_BASE_MASK = ~16'((1 << BLOCK_OFFSET_BITS) - 1);
    localparam logic [CNT_BITS-1:0] NUM_WORDS = CNT_BITS'(WORDS_PER_BLOCK);
    localparam logic [CNT_BITS-1:0] LAST_IDX  = CNT_BITS'(WORDS_PER_BLOCK - 1);

    // The word offset is OR-ed in, so the address can never carry into the tag bits.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [WORD_IDX_BITS-1:0] idx);
        return base | {{(16 - BLOCK_OFFSET_BITS){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between the fill controller (slave) and the cache/memory side (master).
interface cache_fill_fsm_if
    import cache_pkg::*;
();

    logic                     miss_detected;
    logic [15:0]              miss_address;
    logic [15:0]              memory_data;
    logic                     memory_data_valid;
    logic                     fsm_busy;
    logic                     mem_read_en;
    logic [15:0]              memory_address;
    logic                     write_data_array;
    logic [WORD_IDX_BITS-1:0] fill_word;
    logic [15:0]              fill_address;
    logic                     write_tag_array;

    modport master (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, mem_read_en, memory_address, write_data_array,
               fill_word, fill_address, write_tag_array
    );

    modport slave (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, mem_read_en, memory_address, write_data_array,
               fill_word, fill_address, write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small up-counter with synchronous clear and enable, used for request and return indices.
module fill_counter
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [CNT_BITS-1:0] count
);

    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: streams one block of words from pipelined memory into the cache
// data array, writes the tag with the last word and stalls the pipeline meanwhile.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cache_fill_fsm_if.slave bus
);

    fill_state_e         state_q, state_d;
    logic [15:0]         block_base_q, block_base_d;
    logic [CNT_BITS-1:0] req_cnt, rcv_cnt;
    logic                cnt_clr, req_en, rcv_en;

    logic                     busy;
    logic                     rd_en;
    logic [15:0]              rd_addr;
    logic                     wr_data;
    logic [WORD_IDX_BITS-1:0] wr_word;
    logic [15:0]              wr_addr;
    logic                     wr_tag;

    fill_counter u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (req_en),
        .count (req_cnt)
    );

    fill_counter u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (rcv_en),
        .count (rcv_cnt)
    );

    always_comb begin
        state_d      = state_q;
        block_base_d = block_base_q;
        cnt_clr      = 1'b0;
        req_en       = 1'b0;
        rcv_en       = 1'b0;
        busy         = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        wr_data      = 1'b0;
        wr_word      = '0;
        wr_addr      = '0;
        wr_tag       = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                busy = bus.miss_detected;
                if (bus.miss_detected) begin
                    block_base_d = bus.miss_address & BLOCK_BASE_MASK;
                    cnt_clr      = 1'b1;
                    state_d      = FILL_ACTIVE;
                end
            end
            FILL_ACTIVE: begin
                busy = 1'b1;
                if (req_cnt < NUM_WORDS) begin
                    rd_en   = 1'b1;
                    rd_addr = word_addr(block_base_q, req_cnt[WORD_IDX_BITS-1:0]);
                    req_en  = 1'b1;
                end
                if (bus.memory_data_valid) begin
                    wr_data = 1'b1;
                    wr_word = rcv_cnt[WORD_IDX_BITS-1:0];
                    wr_addr = word_addr(block_base_q, rcv_cnt[WORD_IDX_BITS-1:0]);
                    rcv_en  = 1'b1;
                    if (rcv_cnt == LAST_IDX) begin
                        wr_tag  = 1'b1;
                        state_d = FILL_IDLE;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase

        // Nothing may reach the arrays or memory on a reset edge, even mid-fill.
        if (rst) begin
            busy    = 1'b0;
            rd_en   = 1'b0;
            rd_addr = '0;
            wr_data = 1'b0;
            wr_word = '0;
            wr_addr = '0;
            wr_tag  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL_IDLE;
            block_base_q <= '0;
        end else begin
            state_q      <= state_d;
            block_base_q <= block_base_d;
        end
    end

    assign bus.fsm_busy         = busy;
    assign bus.mem_read_en      = rd_en;
    assign bus.memory_address   = rd_addr;
    assign bus.write_data_array = wr_data;
    assign bus.fill_word        = wr_word;
    assign bus.fill_address     = wr_addr;
    assign bus.write_tag_array  = wr_tag;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboarded bench for cache_fill_fsm: a pipelined memory model answers requests,
// expected writes are queued per miss and a negedge monitor checks every DUT strobe.
module tb_cache_fill_fsm;
    import cache_pkg::*;

    typedef struct {
        logic [2:0]  word;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_fill_fsm_if bus();

    cache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int check_count = 0;
    int pass_count  = 0;

    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];
    pend_t       pend[$];

    logic [15:0] data_base = 16'h0000;
    int          gap_mode  = 0;
    bit          stray_req = 1'b0;
    int          stall_cnt = 0;

    int busy_cycles     = 0;
    int wr_count        = 0;
    int miss_cycle      = 0;
    int first_req_cycle = -1;
    int first_wr_cycle  = -1;
    int tag_cycle       = -1;
    bit tag_seen        = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // Reference: a miss fetches the aligned block word by word, tag goes with the last word.
    task automatic push_expect(input logic [15:0] a, input logic [15:0] dbase);
        logic [15:0] base;
        base = a - (a % 16'd16);
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            wr_t e;
            e.word = 3'(i);
            e.addr = base + 16'(2 * i);
            e.data = dbase + 16'(i);
            e.last = (i == WORDS_PER_BLOCK - 1);
            exp_wr.push_back(e);
            exp_req.push_back(e.addr);
        end
    endtask

    task automatic reset_stamps();
        busy_cycles     = 0;
        wr_count        = 0;
        miss_cycle      = cycle_cnt;
        first_req_cycle = -1;
        first_wr_cycle  = -1;
        tag_cycle       = -1;
        tag_seen        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fill_done(input bit noisy);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (bus.write_tag_array) got = 1'b1;
            @(posedge clk);
            #1;
            if (!got && noisy) begin
                bus.miss_detected = 1'($urandom_range(0, 1));
                bus.miss_address  = 16'($urandom);
            end else begin
                bus.miss_detected = 1'b0;
            end
        end
        checkOutput("fill_completes", 32'(got), 32'd1);
        checkOutput("wr_queue_drained", exp_wr.size(), 32'd0);
        checkOutput("req_queue_drained", exp_req.size(), 32'd0);
        if (!got) begin
            exp_wr.delete();
            exp_req.delete();
        end
    endtask

    task automatic drain_memory();
        for (int k = 0; k < 40 && pend.size() > 0; k++) idle(1);
        checkOutput("memory_drained", pend.size(), 32'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] dbase,
                                 input bit noisy, input int gmode);
        gap_mode  = gmode;
        data_base = dbase;
        push_expect(a, dbase);
        reset_stamps();
        bus.miss_detected = 1'b1;
        bus.miss_address  = a;
        wait_fill_done(noisy);
    endtask

    // Memory: captures requests and returns them MEM_LATENCY cycles later, optionally stalled.
    always @(negedge clk) begin
        if (bus.mem_read_en) pend.push_back('{bus.memory_address, cycle_cnt + MEM_LATENCY});
    end

    initial begin
        pend_t p;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            bus.memory_data_valid = 1'b0;
            bus.memory_data       = 16'h0000;
            if (stray_req) begin
                stray_req             = 1'b0;
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'hDEAD;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end else if (pend.size() > 0 && pend[0].due <= cycle_cnt) begin
                p = pend.pop_front();
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = data_base + {13'b0, p.addr[3:1]};
                if (gap_mode == 1 && p.addr[3:1] == 3'd3) begin
                    stall_cnt = 3;
                end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                    stall_cnt = int'($urandom_range(1, 2));
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (bus.fsm_busy) busy_cycles++;
        if (bus.mem_read_en) begin
            if (first_req_cycle < 0) first_req_cycle = cycle_cnt;
            checkOutput("req_expected", 32'(exp_req.size() > 0), 32'd1);
            if (exp_req.size() > 0) checkOutput("req_addr", 32'(bus.memory_address), 32'(exp_req.pop_front()));
        end
        if (bus.write_data_array) begin
            wr_count++;
            if (first_wr_cycle < 0) first_wr_cycle = cycle_cnt;
            checkOutput("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                checkOutput("wr_word", 32'(bus.fill_word), 32'(e.word));
                checkOutput("wr_addr", 32'(bus.fill_address), 32'(e.addr));
                checkOutput("wr_data", 32'(bus.memory_data), 32'(e.data));
                checkOutput("wr_tag", 32'(bus.write_tag_array), 32'(e.last));
            end
        end
        if (bus.write_tag_array) begin
            tag_seen  = 1'b1;
            tag_cycle = cycle_cnt;
            if (!bus.write_data_array) checkOutput("tag_with_write", 32'(bus.write_data_array), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'h0000;

        // Reset held two edges with a pending miss: everything quiet.
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h4446;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_busy", 32'(bus.fsm_busy), 32'd0);
            checkOutput("rst_strobes", 32'({bus.mem_read_en, bus.write_data_array, bus.write_tag_array}), 32'd0);
            checkOutput("rst_mem_addr", 32'(bus.memory_address), 32'd0);
            checkOutput("rst_fill_addr", 32'({bus.fill_word, bus.fill_address}), 32'd0);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        gap_mode  = 0;
        data_base = 16'hB000;
        push_expect(16'h4446, 16'hB000);
        reset_stamps();
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(bus.fsm_busy), 32'd1);
        checkOutput("post_rst_no_req", 32'(bus.mem_read_en), 32'd0);
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b0;
        @(negedge clk);
        checkOutput("fill_entered_req", 32'(bus.mem_read_en), 32'd1);
        @(posedge clk);
        #1;
        wait_fill_done(1'b0);

        // Nominal fill and its cycle-exact timing.
        idle(2);
        applyStimulus(16'h1236, 16'hA000, 1'b0, 0);
        idle(2);
        checkOutput("t1_first_req", 32'(first_req_cycle - miss_cycle), 32'd1);
        checkOutput("t1_first_wr", 32'(first_wr_cycle - miss_cycle), 32'd5);
        checkOutput("t1_tag_cycle", 32'(tag_cycle - miss_cycle), 32'd12);
        checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd13);

        // Top of address space: no wrap into the tag.
        applyStimulus(16'hFFFA, 16'h5000, 1'b0, 0);
        idle(2);
        checkOutput("t2_tag_cycle", 32'(tag_cycle - miss_cycle), 32'd12);

        // Three-cycle gap after word 3.
        applyStimulus(16'h2468, 16'h7700, 1'b0, 1);
        idle(2);
        checkOutput("t3_tag_cycle", 32'(tag_cycle - miss_cycle), 32'd15);
        checkOutput("t3_busy_cycles", 32'(busy_cycles), 32'd16);
        gap_mode = 0;

        // Reset after two words have been written; late returns must be ignored.
        idle(2);
        data_base = 16'h3300;
        push_expect(16'h3000, 16'h3300);
        reset_stamps();
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h3000;
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b0;
        for (int k = 0; k < 20 && wr_count < 2; k++) idle(1);
        checkOutput("t4_words_before_rst", 32'(wr_count), 32'd2);
        rst = 1'b1;
        exp_wr.delete();
        exp_req.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_idle_after_rst", 32'(bus.fsm_busy), 32'd0);
        @(posedge clk);
        #1;
        idle(8);
        drain_memory();
        checkOutput("t4_no_more_writes", 32'(wr_count), 32'd2);
        checkOutput("t4_no_tag", 32'(tag_seen), 32'd0);

        // Miss noise during FILL, then a stray ninth valid.
        idle(2);
        applyStimulus(16'h5552, 16'h9100, 1'b1, 0);
        stray_req = 1'b1;
        idle(3);
        checkOutput("t5_stray_ignored", 32'(wr_count), 32'd8);

        // Randomised fills, some back to back.
        for (int n = 0; n < 20; n++) begin
            logic [15:0] a;
            logic [15:0] d;
            a = 16'($urandom);
            d = 16'($urandom);
            applyStimulus(a, d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)) * 2);
            if ($urandom_range(0, 1) == 1) stray_req = 1'b1;
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(3);
        drain_memory();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
